// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared op and state encodings for the register bank
package reg_bank_pkg;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_INC, OP_CLR} op_e;
  typedef enum logic {ST_IDLE, ST_SWEEP} state_e;
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: write port, read ports and status of the register bank
interface reg_bank_if import reg_bank_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int AW = 3
) ();
  op_e op;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [DATA_WIDTH-1:0] data_in, rd_data_a, rd_data_b;
  logic clear_all, busy, ovf, dropped;
  modport master (
    output op, wr_addr, data_in, clear_all, rd_addr_a, rd_addr_b,
    input rd_data_a, rd_data_b, busy, ovf, dropped
  );
  modport slave (
    input op, wr_addr, data_in, clear_all, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, busy, ovf, dropped
  );
endinterface

// File: rtl/reg_bank_register.sv
// reg_bank_register: single load-enable storage entry
module reg_bank_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: register file with load/inc/clr port, two bypassed read ports and a clear sweep
module reg_bank import reg_bank_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int BYPASS     = 1,
  parameter int SATURATE   = 0
) (
  input logic clk,
  input logic rst,
  reg_bank_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW:0] NR = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  state_e state, state_nxt;
  logic [AW-1:0] idx, idx_nxt, waddr;
  logic [DATA_WIDTH-1:0] q [NUM_REGS];
  logic [DATA_WIDTH-1:0] cur, wval;
  logic wen, valid, ovf_nxt, drop_nxt, ovf_q, drop_q;
  assign valid = {1'b0, bus.wr_addr} < NR;
  assign cur = valid ? q[bus.wr_addr] : '0;
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    wen = 1'b0;
    waddr = bus.wr_addr;
    wval = '0;
    ovf_nxt = 1'b0;
    drop_nxt = 1'b0;
    if (state == ST_SWEEP) begin
      wen = 1'b1;
      waddr = idx;
      drop_nxt = bus.op != OP_NOP;
      idx_nxt = idx == LAST ? '0 : idx + AW'(1);
      state_nxt = idx == LAST ? ST_IDLE : ST_SWEEP;
    end else begin
      wen = valid && bus.op != OP_NOP;
      drop_nxt = !valid && bus.op != OP_NOP;
      ovf_nxt = valid && bus.op == OP_INC && cur == ONES;
      wval = bus.op == OP_LOAD ? bus.data_in :
             bus.op == OP_INC  ? ((SATURATE != 0 && cur == ONES) ? cur : cur + DATA_WIDTH'(1)) : '0;
      state_nxt = bus.clear_all ? ST_SWEEP : ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      idx <= '0;
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      ovf_q <= ovf_nxt;
      drop_q <= drop_nxt;
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg_bank_register #(.WIDTH(DATA_WIDTH)) u_reg (
      .clk(clk), .rst(rst), .en(wen && waddr == AW'(i)), .d(wval), .q(q[i])
    );
  end
  // a read of the entry being written this cycle sees its next value when bypassing
  assign bus.rd_data_a = (BYPASS != 0 && wen && bus.rd_addr_a == waddr) ? wval :
                         ({1'b0, bus.rd_addr_a} < NR ? q[bus.rd_addr_a] : '0);
  assign bus.rd_data_b = (BYPASS != 0 && wen && bus.rd_addr_b == waddr) ? wval :
                         ({1'b0, bus.rd_addr_b} < NR ? q[bus.rd_addr_b] : '0);
  assign bus.busy = state == ST_SWEEP;
  assign bus.ovf = ovf_q;
  assign bus.dropped = drop_q;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vectors for a bypassing wrap bank and a 6-entry saturating non-bypass bank
module tb_reg_bank;
  import reg_bank_pkg::*;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  reg_bank_if #(.DATA_WIDTH(16), .AW(3)) a_if ();
  reg_bank_if #(.DATA_WIDTH(16), .AW(3)) b_if ();
  reg_bank #(.DATA_WIDTH(16), .NUM_REGS(8), .BYPASS(1), .SATURATE(0)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  reg_bank #(.DATA_WIDTH(16), .NUM_REGS(6), .BYPASS(0), .SATURATE(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  int checks = 0, errors = 0;
  typedef struct {
    op_e op; logic [2:0] wa; logic [15:0] d; logic [2:0] ra, rb;
    logic [15:0] ea, eb; logic eo, ed;
  } vec_t;
  vec_t vt [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input op_e op, input logic [2:0] wa, input logic [15:0] d, input logic ca,
                       input logic [2:0] ra, input logic [2:0] rb);
    a_if.op = op; a_if.wr_addr = wa; a_if.data_in = d; a_if.clear_all = ca;
    a_if.rd_addr_a = ra; a_if.rd_addr_b = rb;
  endtask
  task automatic drv_b(input op_e op, input logic [2:0] wa, input logic [15:0] d, input logic ca,
                       input logic [2:0] ra);
    b_if.op = op; b_if.wr_addr = wa; b_if.data_in = d; b_if.clear_all = ca;
    b_if.rd_addr_a = ra; b_if.rd_addr_b = 3'd0;
  endtask
  initial begin
    vt[0]  = '{OP_NOP,  3'd0, 16'h0000, 3'd0, 3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{OP_LOAD, 3'd3, 16'h1234, 3'd3, 3'd3, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vt[2]  = '{OP_NOP,  3'd0, 16'h0000, 3'd3, 3'd2, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vt[3]  = '{OP_LOAD, 3'd5, 16'hFFFF, 3'd5, 3'd3, 16'hFFFF, 16'h1234, 1'b0, 1'b0};
    vt[4]  = '{OP_INC,  3'd5, 16'h0000, 3'd5, 3'd5, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vt[5]  = '{OP_NOP,  3'd0, 16'h0000, 3'd5, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[6]  = '{OP_INC,  3'd3, 16'h0000, 3'd3, 3'd5, 16'h1235, 16'h0000, 1'b0, 1'b0};
    vt[7]  = '{OP_CLR,  3'd3, 16'h0000, 3'd3, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[8]  = '{OP_LOAD, 3'd7, 16'hA5A5, 3'd7, 3'd6, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
    vt[9]  = '{OP_INC,  3'd7, 16'h0000, 3'd7, 3'd3, 16'hA5A6, 16'h0000, 1'b0, 1'b0};
    vt[10] = '{OP_LOAD, 3'd0, 16'h0001, 3'd0, 3'd7, 16'h0001, 16'hA5A6, 1'b0, 1'b0};
    rst = 1'b1;
    drv_a(OP_NOP, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
    drv_b(OP_NOP, 3'd0, 16'h0, 1'b0, 3'd0);
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_if.rd_addr_a = 3'(i);
      #1 chk($sformatf("reset entry %0d", i), a_if.rd_data_a, 16'h0000);
    end
    chk("reset busy", a_if.busy, 1'b0);
    chk("reset ovf", a_if.ovf, 1'b0);
    chk("reset dropped", a_if.dropped, 1'b0);
    chk("b reset busy", b_if.busy, 1'b0);
    for (int i = 0; i < 11; i++) begin
      drv_a(vt[i].op, vt[i].wa, vt[i].d, 1'b0, vt[i].ra, vt[i].rb);
      #1;
      chk($sformatf("vec%0d rd_a", i), a_if.rd_data_a, vt[i].ea);
      chk($sformatf("vec%0d rd_b", i), a_if.rd_data_b, vt[i].eb);
      tick;
      chk($sformatf("vec%0d ovf", i), a_if.ovf, vt[i].eo);
      chk($sformatf("vec%0d dropped", i), a_if.dropped, vt[i].ed);
    end
    for (int i = 0; i < 8; i++) begin
      drv_a(OP_LOAD, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0, 3'd0);
      tick;
    end
    drv_a(OP_INC, 3'd7, 16'h0, 1'b1, 3'd7, 3'd0);
    #1 chk("sweep start inc bypass", a_if.rd_data_a, 16'h1008);
    tick;
    chk("sweep start dropped", a_if.dropped, 1'b0);
    chk("sweep start ovf", a_if.ovf, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sweep%0d busy", k), a_if.busy, 1'b1);
      drv_a(k == 2 ? OP_LOAD : OP_NOP, 3'd6, 16'hDEAD, k == 4, 3'(k), 3'(k + 1));
      #1;
      chk($sformatf("sweep%0d rd_a", k), a_if.rd_data_a, 16'h0000);
      chk($sformatf("sweep%0d rd_b", k), a_if.rd_data_b,
          k == 7 ? 16'h0000 : k == 6 ? 16'h1008 : 16'h1000 + 16'(k + 1));
      tick;
      chk($sformatf("sweep%0d dropped", k), a_if.dropped, k == 2);
    end
    drv_a(OP_NOP, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
    chk("sweep end busy", a_if.busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a_if.rd_addr_a = 3'(i);
      #1 chk($sformatf("swept entry %0d", i), a_if.rd_data_a, 16'h0000);
    end
    tick;
    chk("no restart busy", a_if.busy, 1'b0);
    drv_a(OP_LOAD, 3'd1, 16'h5555, 1'b0, 3'd0, 3'd0); tick;
    drv_a(OP_LOAD, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd0); tick;
    drv_a(OP_NOP, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0); tick;
    a_if.clear_all = 1'b0;
    tick; tick; tick;
    chk("pre-reset busy", a_if.busy, 1'b1);
    rst = 1'b1;
    a_if.rd_addr_a = 3'd6; a_if.rd_addr_b = 3'd1;
    #1;
    chk("async reset busy", a_if.busy, 1'b0);
    chk("async reset entry 6", a_if.rd_data_a, 16'h0000);
    chk("async reset entry 1", a_if.rd_data_b, 16'h0000);
    tick;
    rst = 1'b0;
    drv_a(OP_LOAD, 3'd2, 16'h7777, 1'b0, 3'd2, 3'd6);
    tick;
    drv_a(OP_NOP, 3'd0, 16'h0, 1'b0, 3'd2, 3'd6);
    #1;
    chk("post-reset load", a_if.rd_data_a, 16'h7777);
    chk("post-reset entry 6", a_if.rd_data_b, 16'h0000);
    chk("post-reset busy", a_if.busy, 1'b0);
    drv_b(OP_LOAD, 3'd7, 16'h1111, 1'b0, 3'd7);
    #1 chk("b oob read", b_if.rd_data_a, 16'h0000);
    tick;
    chk("b oob dropped", b_if.dropped, 1'b1);
    drv_b(OP_LOAD, 3'd3, 16'h1234, 1'b0, 3'd3);
    #1 chk("b no bypass", b_if.rd_data_a, 16'h0000);
    tick;
    chk("b dropped clears", b_if.dropped, 1'b0);
    chk("b load visible", b_if.rd_data_a, 16'h1234);
    drv_b(OP_LOAD, 3'd5, 16'hFFFF, 1'b0, 3'd5); tick;
    drv_b(OP_INC, 3'd5, 16'h0, 1'b0, 3'd5);
    #1 chk("b inc no bypass", b_if.rd_data_a, 16'hFFFF);
    tick;
    chk("b sat ovf", b_if.ovf, 1'b1);
    chk("b sat hold", b_if.rd_data_a, 16'hFFFF);
    drv_b(OP_INC, 3'd6, 16'h0, 1'b0, 3'd5); tick;
    chk("b oob inc dropped", b_if.dropped, 1'b1);
    chk("b oob inc ovf", b_if.ovf, 1'b0);
    drv_b(OP_NOP, 3'd0, 16'h0, 1'b1, 3'd3); tick;
    b_if.clear_all = 1'b0;
    begin
      int n = 0;
      for (int c = 0; c < 20 && b_if.busy; c++) begin
        n++;
        tick;
      end
      chk("b sweep length", n, 6);
    end
    chk("b swept entry 3", b_if.rd_data_a, 16'h0000);
    b_if.rd_addr_a = 3'd5;
    #1 chk("b swept entry 5", b_if.rd_data_a, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
